// File: rtl/uart_word_ctrl_if.sv
// uart_word_ctrl_if: UART byte handshake plus datapath operand/result word handshakes.
// The master modport is the controller's view; slave is the UART/datapath side.
interface uart_word_ctrl_if #(
  parameter int WORD_W = 32
);
  logic              rx_readable;
  logic [7:0]        rx_data;
  logic              rx_used_tick;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              rx_err;

  modport master (
    input  rx_readable, rx_data, tx_busy, in_ready, out_data, out_valid,
    output rx_used_tick, tx_start, tx_data, in_data, in_valid, out_ready, rx_err
  );

  modport slave (
    output rx_readable, rx_data, tx_busy, in_ready, out_data, out_valid,
    input  rx_used_tick, tx_start, tx_data, in_data, in_valid, out_ready, rx_err
  );
endinterface

// File: rtl/uart_word_ctrl.sv
// uart_word_ctrl: packs received UART bytes into WORD_W operands and serialises result words, LSB byte first.
// Optional macro UART_CTRL_TIMEOUT_EN discards a stalled partial RX word after TIMEOUT_CYC idle cycles.
module uart_word_ctrl #(
  parameter int WORD_W      = 32,
  parameter int TIMEOUT_CYC = 100000
) (
  input logic              clk,
  input logic              rst_n,
  uart_word_ctrl_if.master bus
);
  localparam int NBYTES = WORD_W / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    RX_COLLECT = 2'd0,
    RX_ACK     = 2'd1,
    RX_HOLD    = 2'd2
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_START   = 2'd1,
    TX_WAIT_HI = 2'd2,
    TX_WAIT_LO = 2'd3
  } tx_state_e;

  rx_state_e         rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [WORD_W-1:0] rx_buf_q, rx_buf_d;
  logic              rx_used_q, rx_used_d;
  logic              in_valid_q, in_valid_d;

  tx_state_e         tx_state_q, tx_state_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [WORD_W-1:0] tx_buf_q, tx_buf_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              out_ready_q, out_ready_d;

`ifdef UART_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            rx_err_q, rx_err_d;

  // Inter-byte idle counter and its discard pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= {TO_W{1'b0}};
      rx_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      rx_err_q <= rx_err_d;
    end
  end

  assign bus.rx_err = rx_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign bus.rx_err         = 1'b0;
`endif

  // RX state, byte lanes and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_COLLECT;
      rx_cnt_q   <= {CNT_W{1'b0}};
      rx_buf_q   <= {WORD_W{1'b0}};
      rx_used_q  <= 1'b0;
      in_valid_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_buf_q   <= rx_buf_d;
      rx_used_q  <= rx_used_d;
      in_valid_q <= in_valid_d;
    end
  end

  // RX next-state: collect a byte, absorb the UART's stale readable for a cycle, then present the word
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_buf_d   = rx_buf_q;
    rx_used_d  = 1'b0;
    in_valid_d = in_valid_q;
`ifdef UART_CTRL_TIMEOUT_EN
    to_cnt_d   = {TO_W{1'b0}};
    rx_err_d   = 1'b0;
`endif
    case (rx_state_q)
      RX_COLLECT: begin
        if (bus.rx_readable) begin
          rx_buf_d[{rx_cnt_q, 3'b000} +: 8] = bus.rx_data;
          rx_cnt_d   = (rx_cnt_q == LAST_LANE) ? {CNT_W{1'b0}} : rx_cnt_q + 1'b1;
          rx_used_d  = 1'b1;
          rx_state_d = RX_ACK;
        end else begin
`ifdef UART_CTRL_TIMEOUT_EN
          if (rx_cnt_q != {CNT_W{1'b0}}) begin
            if (to_cnt_q == TO_LAST) begin
              rx_cnt_d = {CNT_W{1'b0}};
              rx_buf_d = {WORD_W{1'b0}};
              rx_err_d = 1'b1;
            end else begin
              to_cnt_d = to_cnt_q + 1'b1;
            end
          end else begin
            to_cnt_d = {TO_W{1'b0}};
          end
`else
          rx_state_d = RX_COLLECT;
`endif
        end
      end
      RX_ACK: begin
        // A wrapped counter after a consumed byte means the word is complete
        if (rx_cnt_q == {CNT_W{1'b0}}) begin
          rx_state_d = RX_HOLD;
          in_valid_d = 1'b1;
        end else begin
          rx_state_d = RX_COLLECT;
        end
      end
      RX_HOLD: begin
        if (bus.in_ready) begin
          in_valid_d = 1'b0;
          rx_state_d = RX_COLLECT;
        end else begin
          in_valid_d = 1'b1;
        end
      end
      default: begin
        rx_state_d = RX_COLLECT;
        in_valid_d = 1'b0;
      end
    endcase
  end

  // TX state, word buffer and UART strobe outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= {CNT_W{1'b0}};
      tx_buf_q    <= {WORD_W{1'b0}};
      tx_data_q   <= 8'h00;
      tx_start_q  <= 1'b0;
      out_ready_q <= 1'b1;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_buf_q    <= tx_buf_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      out_ready_q <= out_ready_d;
    end
  end

  // TX next-state: one byte per busy high/low cycle of the UART transmitter
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_buf_d    = tx_buf_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    out_ready_d = out_ready_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (bus.out_valid) begin
          tx_buf_d    = bus.out_data;
          tx_cnt_d    = {CNT_W{1'b0}};
          out_ready_d = 1'b0;
          tx_state_d  = TX_START;
        end else begin
          out_ready_d = 1'b1;
        end
      end
      TX_START: begin
        if (!bus.tx_busy) begin
          tx_data_d  = tx_buf_q[{tx_cnt_q, 3'b000} +: 8];
          tx_start_d = 1'b1;
          tx_state_d = TX_WAIT_HI;
        end else begin
          tx_state_d = TX_START;
        end
      end
      TX_WAIT_HI: begin
        if (bus.tx_busy) begin
          tx_state_d = TX_WAIT_LO;
        end else begin
          tx_state_d = TX_WAIT_HI;
        end
      end
      TX_WAIT_LO: begin
        if (!bus.tx_busy) begin
          if (tx_cnt_q == LAST_LANE) begin
            tx_cnt_d    = {CNT_W{1'b0}};
            out_ready_d = 1'b1;
            tx_state_d  = TX_IDLE;
          end else begin
            tx_cnt_d   = tx_cnt_q + 1'b1;
            tx_state_d = TX_START;
          end
        end else begin
          tx_state_d = TX_WAIT_LO;
        end
      end
      default: begin
        tx_state_d  = TX_IDLE;
        out_ready_d = 1'b1;
      end
    endcase
  end

  // The lane buffer only changes while collecting, so it doubles as the held operand
  assign bus.in_data      = rx_buf_q;
  assign bus.in_valid     = in_valid_q;
  assign bus.rx_used_tick = rx_used_q;
  assign bus.tx_data      = tx_data_q;
  assign bus.tx_start     = tx_start_q;
  assign bus.out_ready    = out_ready_q;
endmodule

// File: doc/uart_word_ctrl.md
Name: uart_word_ctrl

Overview:
- Sequencing controller between the UART byte core and the RSA datapath.
- Drives the UART's rx_used_tick, tx_start and tx_data handshake signals.
- RX side: assembles WORD_W-bit operands from consecutive received bytes, LSB byte first, and presents each operand on a valid/ready port.
- TX side: accepts result words on a valid/ready port and serialises them to the UART, LSB byte first.
- Replaces the ad-hoc per-byte echo logic used for UART bring-up.

Parameters:
- WORD_W, 32, operand/result width in bits; must be a multiple of 8, minimum 8.
- TIMEOUT_CYC, 100000, maximum idle cycles between bytes of one RX word. Used only with UART_CTRL_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_readable  in  1  from UART: a received byte is available.
- rx_data  in  8  from UART: received byte.
- rx_used_tick  out  1  to UART: one-cycle pulse, byte consumed.
- tx_start  out  1  to UART: one-cycle pulse, start byte transmission.
- tx_data  out  8  to UART: byte to send; held stable until tx_busy falls.
- tx_busy  in  1  from UART: transmitter active.
- in_data  out  WORD_W  assembled operand to datapath.
- in_valid  out  1  in_data valid.
- in_ready  in  1  datapath accepts in_data.
- out_data  in  WORD_W  result word from datapath.
- out_valid  in  1  out_data valid.
- out_ready  out  1  controller can accept a result word.
- rx_err  out  1  one-cycle pulse: partial word discarded (feature only; tied 0 otherwise).

Behaviour:
- Reset values:
  - rx_used_tick, tx_start, in_valid, rx_err = 0.
  - in_data, tx_data = 0.
  - out_ready = 1.
  - Both FSMs in IDLE; byte counters = 0.
- Reset mid-operation: any partial word and any in-flight TX word are dropped. A UART frame already started completes inside the UART; the controller ignores it.
- RX FSM, states RX_COLLECT, RX_ACK, RX_HOLD:
  - RX_COLLECT, with rx_readable=1: write rx_data into byte lane rx_cnt of the shift buffer, increment rx_cnt, assert rx_used_tick on the next cycle (registered), go to RX_ACK.
  - RX_ACK lasts exactly one cycle. rx_readable is ignored during it, so one byte is never consumed twice.
  - RX_ACK -> RX_HOLD if rx_cnt has reached WORD_W/8 (counter wraps to 0); otherwise -> RX_COLLECT.
  - RX_HOLD: in_valid=1, in_data stable. On in_valid && in_ready: clear in_valid, go to RX_COLLECT.
  - While in RX_HOLD no bytes are consumed; the UART holds rx_readable (back-pressure).
  - Latency: in_valid rises 2 cycles after rx_readable of the last byte.
- TX FSM, states TX_IDLE, TX_START, TX_WAIT_HI, TX_WAIT_LO:
  - TX_IDLE: out_ready=1. On out_valid: latch out_data into the TX buffer, tx_cnt=0, out_ready=0, go to TX_START.
  - TX_START: when tx_busy=0, drive tx_data = buffer byte tx_cnt, pulse tx_start for 1 cycle, go to TX_WAIT_HI. If tx_busy=1, stay in TX_START.
  - TX_WAIT_HI: wait for tx_busy=1, then go to TX_WAIT_LO.
  - TX_WAIT_LO: wait for tx_busy=0, then increment tx_cnt.
    - Last byte sent -> TX_IDLE (out_ready returns to 1 on the next cycle).
    - Otherwise -> TX_START.
  - tx_data changes only in TX_START.
- RX and TX FSMs are independent. Simultaneous RX byte arrival and TX activity are both serviced with no interaction.
- WORD_W=8 degenerates to a single-byte pass-through with handshakes.

Optional Feature:
- Macro: UART_CTRL_TIMEOUT_EN.
- Defined:
  - A counter clears on every consumed byte and counts while rx_cnt != 0 in RX_COLLECT.
  - When the count reaches TIMEOUT_CYC: rx_cnt=0, buffer cleared, rx_err pulses for 1 cycle, FSM stays in RX_COLLECT.
  - The counter is idle when rx_cnt=0 and in RX_HOLD.
- Undefined: no counter logic is instantiated, rx_err is tied 0, and partial words wait indefinitely.

Test Plan:
- WORD_W=32, bytes 0x11,0x22,0x33,0x44 with in_ready=1 -> in_data=0x44332211, in_valid high one cycle, exactly 4 rx_used_tick pulses.
- rx_readable held high for 3 cycles per byte -> each byte consumed once, rx_used_tick count equals byte count.
- in_ready=0 for 50 cycles after a word while byte 0x55 is pending -> no rx_used_tick until handshake completes; next word's lane 0 = 0x55.
- out_data=0xDEADBEEF, UART model busy 20 cycles per byte -> tx_data sequence EF,BE,AD,DE; 4 tx_start pulses each with tx_busy low; out_ready=0 throughout, then 1.
- rst_n low after byte 2 of an RX word and during TX byte 1 -> all outputs at reset values; the next full word is assembled correctly.
- With UART_CTRL_TIMEOUT_EN and TIMEOUT_CYC=50: send 2 bytes, idle 60 cycles -> rx_err pulse; next 4 bytes give a correct word.
